// File: rtl/clk_div_seq.sv
// PLL-lock reset sequencer plus NCH glitch-free clock-enable / divided-clock channels.
// Define CLKDIV_SYNC_EN to add the sync_req port that phase-aligns all channels.
module clk_div_seq #(
  parameter int NCH       = 2,
  parameter int DW        = 8,
  parameter int DIV_INIT  = 1,
  parameter int LOCK_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic [NCH-1:0]    div_ld,
  input  logic [NCH*DW-1:0] div_val,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_req,
`endif
  output logic [NCH-1:0]    en_o,
  output logic [NCH-1:0]    clk_o,
  output logic              run_rst_n,
  output logic              ready
);

  localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {S_WAIT_LOCK, S_SETTLE, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [SW-1:0]   r_settle, w_settle_nxt;
  logic            r_lock_s1, r_lock_s2;
  logic            r_run;
  logic            w_run_nxt;
  logic            w_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_state   <= S_WAIT_LOCK;
      r_settle  <= '0;
      r_run     <= 1'b0;
    end else begin
      r_lock_s1 <= pll_lock;
      r_lock_s2 <= r_lock_s1;
      r_state   <= w_state_nxt;
      r_settle  <= w_settle_nxt;
      r_run     <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    unique case (r_state)
      S_WAIT_LOCK: begin
        if (r_lock_s2) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = '0;
        end
      end
      S_SETTLE: begin
        if (!r_lock_s2)                  w_state_nxt  = S_WAIT_LOCK;
        else if (r_settle == SETTLE_LAST) w_state_nxt  = S_RUN;
        else                              w_settle_nxt = r_settle + SW'(1);
      end
      S_RUN: begin
        if (!r_lock_s2) w_state_nxt = S_WAIT_LOCK;
      end
      default: w_state_nxt = S_WAIT_LOCK;
    endcase
  end

  // r_run is the registered image of (state == RUN); both reset outputs share it
  assign w_run_nxt = (w_state_nxt == S_RUN);
  assign ready     = r_run;
  assign run_rst_n = r_run;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_req & r_run;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] r_act, r_pend, r_cnt;
    logic          r_flag, r_clk;
    logic [DW-1:0] w_act_nxt, w_pend_nxt, w_cnt_nxt;
    logic          w_flag_nxt, w_clk_nxt;
    logic [DW-1:0] w_val;

    assign w_val = div_val[i*DW +: DW];

    always_comb begin
      w_act_nxt  = r_act;
      w_pend_nxt = r_pend;
      w_flag_nxt = r_flag;
      w_cnt_nxt  = r_cnt;
      if (!r_run) begin
        if (div_ld[i]) begin
          w_act_nxt  = w_val;
          w_flag_nxt = 1'b0;
        end else if (r_flag) begin
          w_act_nxt  = r_pend;
          w_flag_nxt = 1'b0;
        end
        w_cnt_nxt = w_act_nxt;
      end else if (w_sync || (r_cnt == '0)) begin
        // Wrap or forced realignment: a same-cycle load beats any pending divisor
        if (div_ld[i])   w_act_nxt = w_val;
        else if (r_flag) w_act_nxt = r_pend;
        w_flag_nxt = 1'b0;
        w_cnt_nxt  = w_act_nxt;
      end else begin
        w_cnt_nxt = r_cnt - DW'(1);
        if (div_ld[i]) begin
          w_pend_nxt = w_val;
          w_flag_nxt = 1'b1;
        end
      end
    end

    // Gated on both current and next run so entry/exit never produce a runt high
    assign w_clk_nxt = r_run & w_run_nxt & (r_cnt > (r_act >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act  <= DW'(DIV_INIT);
        r_pend <= '0;
        r_flag <= 1'b0;
        r_cnt  <= DW'(DIV_INIT);
        r_clk  <= 1'b0;
      end else begin
        r_act  <= w_act_nxt;
        r_pend <= w_pend_nxt;
        r_flag <= w_flag_nxt;
        r_cnt  <= w_cnt_nxt;
        r_clk  <= w_clk_nxt;
      end
    end

    assign en_o[i]  = r_run & (r_cnt == '0) & ~w_sync;
    assign clk_o[i] = r_clk;
  end

endmodule

// File: tb/tb_clk_div_seq.sv
// Scoreboarded bench for clk_div_seq: a phase-counting reference model predicts every
// cycle's outputs, and directed measurements check latencies and periods.
module tb_clk_div_seq;
  localparam int NCH = 2, DW = 8, DIV_INIT = 1, LOCK_WAIT = 16;
  localparam int OW  = 2 + 2*NCH;

  logic              clk = 1'b0;
  logic              rst_n, pll_lock;
  logic [NCH-1:0]    div_ld;
  logic [NCH*DW-1:0] div_val;
`ifdef CLKDIV_SYNC_EN
  logic              sync_req;
`endif
  logic [NCH-1:0]    en_o, clk_o;
  logic              run_rst_n, ready;

  int errs = 0, checks = 0;

  // Reference model: state 0=WAIT_LOCK 1=SETTLE 2=RUN; pos counts up 0..N within a period
  bit m_s1, m_s2;
  int m_state, m_settle;
  int m_act [NCH], m_pend [NCH], m_pos [NCH];
  bit m_flag [NCH], m_clk [NCH];
  logic [OW-1:0] sb_q [$];

  always #5 clk = ~clk;

  clk_div_seq #(.NCH(NCH), .DW(DW), .DIV_INIT(DIV_INIT), .LOCK_WAIT(LOCK_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .div_ld(div_ld), .div_val(div_val),
`ifdef CLKDIV_SYNC_EN
    .sync_req(sync_req),
`endif
    .en_o(en_o), .clk_o(clk_o), .run_rst_n(run_rst_n), .ready(ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_state = 0; m_settle = 0;
    for (int i = 0; i < NCH; i++) begin
      m_act[i] = DIV_INIT; m_pend[i] = 0; m_pos[i] = 0; m_flag[i] = 0; m_clk[i] = 0;
    end
  endfunction

  function automatic bit model_sync();
`ifdef CLKDIV_SYNC_EN
    return sync_req && (m_state == 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [NCH-1:0] e, c;
    bit run = (m_state == 2);
    for (int i = 0; i < NCH; i++) begin
      e[i] = run && (m_pos[i] == m_act[i]) && !model_sync();
      c[i] = m_clk[i];
    end
    return {run, run, e, c};
  endfunction

  function automatic void model_step();
    bit run, nrun, sy;
    int nst, v;
    if (!rst_n) begin model_reset(); return; end
    run = (m_state == 2);
    sy  = model_sync();
    nst = m_state;
    case (m_state)
      0: if (m_s2) begin nst = 1; m_settle = 0; end
      1: if (!m_s2) nst = 0;
         else if (m_settle == LOCK_WAIT-1) nst = 2;
         else m_settle++;
      default: if (!m_s2) nst = 0;
    endcase
    nrun = (nst == 2);
    for (int i = 0; i < NCH; i++) begin
      v = int'(div_val[i*DW +: DW]);
      m_clk[i] = run && nrun && (m_pos[i] < m_act[i] - (m_act[i] / 2));
      if (!run) begin
        if (div_ld[i]) begin m_act[i] = v; m_flag[i] = 0; end
        else if (m_flag[i]) begin m_act[i] = m_pend[i]; m_flag[i] = 0; end
        m_pos[i] = 0;
      end else if (sy || m_pos[i] == m_act[i]) begin
        if (div_ld[i]) m_act[i] = v;
        else if (m_flag[i]) m_act[i] = m_pend[i];
        m_flag[i] = 0;
        m_pos[i]  = 0;
      end else begin
        m_pos[i]++;
        if (div_ld[i]) begin m_pend[i] = v; m_flag[i] = 1; end
      end
    end
    m_s2 = m_s1; m_s1 = pll_lock; m_state = nst;
  endfunction

  // One cycle: inputs already set just after a falling edge; ends after the next falling edge
  task automatic step();
    sb_q.push_back(model_out());
    #1;
    check_eq("out", {ready, run_rst_n, en_o, clk_o}, sb_q.pop_front());
    model_step();
    @(negedge clk);
    div_ld = '0;
`ifdef CLKDIV_SYNC_EN
    sync_req = 1'b0;
`endif
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input int ch, input int v);
    div_ld[ch] = 1'b1;
    div_val[ch*DW +: DW] = DW'(v);
  endtask

  task automatic wait_ready(input string tag, input int exp);
    int n = 0;
    while (!ready && n < 60) begin step(); n++; end
    check_eq(tag, n, exp);
  endtask

  task automatic en_wait(input int ch, output int n);
    n = 0;
    while (!en_o[ch] && n < 40) begin step(); n++; end
  endtask

  task automatic en_gap(input int ch, output int g);
    int n;
    en_wait(ch, n);
    step();
    g = 1;
    while (!en_o[ch] && g < 40) begin step(); g++; end
  endtask

  task automatic hi_count(input int ch, input int len, output int c);
    c = 0;
    repeat (len) begin step(); if (clk_o[ch]) c++; end
  endtask

  initial begin
    int g, n, k;
    rst_n = 1'b0; pll_lock = 1'b0; div_ld = '0; div_val = '0;
`ifdef CLKDIV_SYNC_EN
    sync_req = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    run(3);
    check_eq("rst_ready", {ready, run_rst_n, en_o, clk_o}, 0);
    rst_n = 1'b1;
    run(2);

    // Divisors loaded while idle apply immediately; then lock and sequence to RUN
    load(0, 3); load(1, 2); step();
    pll_lock = 1'b1;
    wait_ready("ready_lat", 3 + LOCK_WAIT);

    en_gap(0, g);     check_eq("gap_n3", g, 4);
    en_gap(1, g);     check_eq("gap_n2", g, 3);
    hi_count(0, 12, n); check_eq("hi_n3", n, 6);
    hi_count(1, 12, n); check_eq("hi_n2", n, 4);

    load(1, 0); run(3);
    en_gap(1, g);     check_eq("gap_n0", g, 1);
    hi_count(1, 8, n);  check_eq("hi_n0", n, 0);
    load(1, 2); run(2);

    // Mid-period change on channel 0: current period finishes, then period 6
    k = 0;
    while (m_pos[0] != 1 && k < 20) begin step(); k++; end
    load(0, 5); step();
    en_gap(0, g);     check_eq("gap_n5", g, 6);
    en_gap(1, g);     check_eq("gap_ch1", g, 3);

    // Load coincident with the wrap is used at that wrap
    k = 0;
    while (m_pos[0] != m_act[0] && k < 20) begin step(); k++; end
    load(0, 2); step();
    en_wait(0, n);    check_eq("wrap_ld", n, 2);

    // Two loads inside one period: only the later one survives
    step();
    load(0, 4); step();
    load(0, 6); step();
    en_gap(0, g);     check_eq("last_ld", g, 7);

    // Lock loss: ready and enables drop three cycles after pll_lock
    pll_lock = 1'b0;
    n = 0;
    while (ready && n < 20) begin step(); n++; end
    check_eq("loss_lat", n, 3);
    check_eq("loss_en", en_o, 0);
    run(2);
    check_eq("loss_clk", clk_o, 0);

    // Lock glitch during SETTLE restarts the full wait
    pll_lock = 1'b1; run(8);
    pll_lock = 1'b0; run(2);
    pll_lock = 1'b1;
    wait_ready("glitch_lat", 3 + LOCK_WAIT);
    run(5);

`ifdef CLKDIV_SYNC_EN
    load(0, 3); load(1, 5); step();
    run(2);
    sync_req = 1'b1; step();
    g = -1; n = -1;
    for (int j = 1; j <= 10; j++) begin
      if (en_o[0] && g < 0) g = j;
      if (en_o[1] && n < 0) n = j;
      step();
    end
    check_eq("sync_ch0", g, 4);
    check_eq("sync_ch1", n, 6);
`endif

    // Asynchronous reset mid-run clears outputs before any clock edge
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst", {ready, run_rst_n, en_o, clk_o}, 0);
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
    run(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
